// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Control FSM that steps one RV32I instruction at a time through
//   FETCH / DECODE / EXEC / MEM / WB. It drives the instruction and data
//   memory handshakes and the datapath strobes. It does not select ALU
//   operations; the opcode decoder beside it does that.
//
//   Optional feature macro: PERF_CNT_EN
//     defined   -> cycle_count / instret_count are live counters
//     undefined -> no counter flops, both outputs tied to zero
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   run            start/continue execution, sampled at instruction boundary
//   opcode         instr[6:0] from IR, valid in DECODE
//   branch_taken   ALU compare result, valid in EXEC
//   imem_req       instruction fetch request
//   imem_ready     fetch data valid (qualified by imem_req)
//   dmem_req       data memory request
//   dmem_we        1 = store, 0 = load (qualified by dmem_req)
//   dmem_ready     data access complete (qualified by dmem_req)
//   ir_load        pulse: latch fetched word into IR
//   pc_write       pulse: update PC from pc_src
//   pc_src         00 pc+4, 01 branch/jal target, 10 jalr target
//   reg_write      pulse: regfile write-back
//   illegal_instr  high while trapped on an unknown opcode
//   cycle_count    active (non-IDLE) cycles
//   instret_count  retired instructions
//
// state  | meaning
// IDLE   | waiting for run at an instruction boundary
// FETCH  | imem_req held until imem_ready
// DECODE | capture opcode, check legality
// EXEC   | branch resolves and retires here; others route on
// MEM    | dmem_req held until dmem_ready; store retires here
// WB     | regfile write + PC update, retire
// TRAP   | unknown opcode; only reset leaves
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t     state;
  logic [6:0] op_q;
  logic       legal;
  logic       is_load;
  logic       is_store;
  logic       is_branch;

  // Legality is judged on the live opcode since op_q only updates at the
  // end of DECODE.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          op_q  <= opcode;
          state <= legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_load || is_store) state <= S_MEM;
          else if (is_branch)      state <= run ? S_FETCH : S_IDLE;
          else                     state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_load) state <= S_WB;
            else         state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_WB:    state <= run ? S_FETCH : S_IDLE;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decoded from state and op_q; handshake completions (ir_load,
  // store PC update) and the branch PC select follow the live inputs so no
  // extra cycle is spent per step.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = {1'b0, branch_taken};
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_write = is_store && dmem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (op_q == OP_JAL)       pc_src = 2'b01;
        else if (op_q == OP_JALR) pc_src = 2'b10;
        else                      pc_src = 2'b00;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  assign retire = ((state == S_EXEC) && is_branch) ||
                  ((state == S_MEM) && is_store && dmem_ready) ||
                  (state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != S_IDLE) cycle_q   <= cycle_q + CNT_W'(1);
      if (retire)          instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int CNT_W = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Expected vector layout:
  // [8] imem_req [7] dmem_req [6] dmem_we [5] ir_load [4] pc_write
  // [3:2] pc_src [1] reg_write [0] illegal_instr
  localparam logic [8:0] V_ZERO      = 9'b0_0_0_0_0_00_0_0;
  localparam logic [8:0] V_FETCH     = 9'b1_0_0_0_0_00_0_0;
  localparam logic [8:0] V_FETCH_ACC = 9'b1_0_0_1_0_00_0_0;
  localparam logic [8:0] V_TRAP      = 9'b0_0_0_0_0_00_0_1;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             ir_load;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             illegal_instr;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;
  logic [8:0]       obs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       run;
    logic [6:0] op;
    logic       ir;
    logic       dr;
    logic       tk;
  } stim_t;

  logic [8:0] exp_q[$];
  stim_t      stim_q[$];

  multicycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .illegal_instr(illegal_instr),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  assign obs = {imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_src, reg_write, illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
           (op == OP_AUIPC);
  endfunction

  task automatic push(input logic [8:0] e, input logic r, input logic [6:0] op,
                      input logic ir, input logic dr, input logic tk);
    stim_t s;
    s = '{run: r, op: op, ir: ir, dr: dr, tk: tk};
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  task automatic push_idle(input logic r, input int n);
    for (int i = 0; i < n; i++) push(V_ZERO, r, 7'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Queue one instruction starting in FETCH. run is inverted on every cycle
  // except the retire cycle, so a sequencer that looks at run mid-instruction
  // goes astray. Ready lines are held high outside their own state to show
  // they are ignored without the matching request.
  task automatic gen_instr(input logic [6:0] op, input logic tk, input int iw,
                           input int dw, input logic r);
    logic       m;
    logic       st;
    logic [1:0] src;
    m  = ~r;
    st = (op == OP_STORE);
    for (int i = 0; i < iw; i++) push(V_FETCH, m, op, 1'b0, 1'b1, tk);
    push(V_FETCH_ACC, m, op, 1'b1, 1'b1, tk);
    push(V_ZERO, m, op, 1'b1, 1'b1, tk);
    if (!is_legal(op)) return;
    if (op == OP_BR) begin
      push({5'b00001, 1'b0, tk, 2'b00}, r, op, 1'b1, 1'b1, tk);
      return;
    end
    push(V_ZERO, m, op, 1'b1, 1'b1, tk);
    if (op == OP_LOAD || st) begin
      for (int i = 0; i < dw; i++) push({2'b01, st, 6'b0}, m, op, 1'b1, 1'b0, tk);
      push({2'b01, st, 1'b0, st, 4'b0}, st ? r : m, op, 1'b1, 1'b1, tk);
      if (st) return;
    end
    if (op == OP_JAL)       src = 2'b01;
    else if (op == OP_JALR) src = 2'b10;
    else                    src = 2'b00;
    push({5'b00001, src, 2'b10}, r, op, 1'b1, 1'b1, tk);
  endtask

  // Scoreboard consumer: drive each queued cycle, compare at the falling edge.
  task automatic drain(input string name);
    stim_t      s;
    logic [8:0] e;
    int         n;
    n = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      run          = s.run;
      opcode       = s.op;
      imem_ready   = s.ir;
      dmem_ready   = s.dr;
      branch_taken = s.tk;
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %b want %b", name, n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (obs !== V_ZERO) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, V_ZERO);
    end
    checks++;
    if (cycle_count !== '0 || instret_count !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_count, instret_count);
    end
    @(posedge clk);
    #1;
    push_idle(1'b0, 3);
    drain("idle_hold");
  endtask

  task automatic test_alu();
    push_idle(1'b1, 1);
    gen_instr(OP_R,     1'b0, 0, 0, 1'b1);
    gen_instr(OP_I,     1'b1, 0, 0, 1'b1);
    gen_instr(OP_LUI,   1'b0, 1, 0, 1'b1);
    gen_instr(OP_AUIPC, 1'b0, 0, 0, 1'b0);
    push_idle(1'b0, 2);
    drain("alu");
  endtask

  task automatic test_load_wait();
    push_idle(1'b1, 1);
    gen_instr(OP_LOAD, 1'b0, 0, 3, 1'b1);
    gen_instr(OP_LOAD, 1'b0, 2, 0, 1'b0);
    push_idle(1'b0, 1);
    drain("load");
  endtask

  task automatic test_store();
    push_idle(1'b1, 1);
    gen_instr(OP_STORE, 1'b0, 0, 0, 1'b1);
    gen_instr(OP_STORE, 1'b1, 1, 2, 1'b0);
    push_idle(1'b0, 1);
    drain("store");
  endtask

  task automatic test_branch_jump();
    push_idle(1'b1, 1);
    gen_instr(OP_BR,   1'b1, 0, 0, 1'b1);
    gen_instr(OP_BR,   1'b0, 0, 0, 1'b1);
    gen_instr(OP_JAL,  1'b0, 0, 0, 1'b1);
    gen_instr(OP_JALR, 1'b1, 0, 0, 1'b0);
    push_idle(1'b0, 1);
    drain("branch_jump");
  endtask

  task automatic test_trap();
    push_idle(1'b1, 1);
    gen_instr(7'b0000000, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) push(V_TRAP, 1'b1, 7'b0000000, 1'b1, 1'b1, 1'b0);
    drain("trap_zero");
    do_reset();
    @(negedge clk);
    checks++;
    if (illegal_instr !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset: illegal %b imem_req %b want 0 0", illegal_instr, imem_req);
    end
    @(posedge clk);
    #1;
    push_idle(1'b1, 1);
    gen_instr(7'b1111111, 1'b0, 1, 0, 1'b1);
    for (int i = 0; i < 3; i++) push(V_TRAP, 1'b1, 7'b1111111, 1'b1, 1'b1, 1'b0);
    drain("trap_ones");
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    push_idle(1'b1, 1);
    push(V_FETCH_ACC, 1'b1, OP_LOAD, 1'b1, 1'b1, 1'b0);
    push(V_ZERO,      1'b1, OP_LOAD, 1'b1, 1'b1, 1'b0);
    push(V_ZERO,      1'b1, OP_LOAD, 1'b1, 1'b1, 1'b0);
    push(9'b0_1_0_0_0_00_0_0, 1'b1, OP_LOAD, 1'b1, 1'b0, 1'b0);
    push(9'b0_1_0_0_0_00_0_0, 1'b1, OP_LOAD, 1'b1, 1'b0, 1'b0);
    drain("pre_reset_mem");
    rst_n      = 1'b0;
    run        = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_before_reset: dmem_req got %b want 1", dmem_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== V_ZERO || cycle_count !== '0 || instret_count !== '0) begin
      errors++;
      $display("FAIL mem_reset: outputs %b counters %0d/%0d want all 0", obs, cycle_count,
               instret_count);
    end
    @(posedge clk);
    #1;
    gen_instr(OP_STORE, 1'b0, 0, 0, 1'b0);
    push_idle(1'b0, 1);
    drain("restart_after_reset");
  endtask

  task automatic test_back_to_back_perf();
    logic [CNT_W-1:0] exp_cyc;
    logic [CNT_W-1:0] exp_ret;
`ifdef PERF_CNT_EN
    exp_cyc = CNT_W'(12);
    exp_ret = CNT_W'(3);
`else
    exp_cyc = '0;
    exp_ret = '0;
`endif
    do_reset();
    push_idle(1'b1, 1);
    gen_instr(OP_R, 1'b0, 0, 0, 1'b1);
    gen_instr(OP_R, 1'b0, 0, 0, 1'b1);
    gen_instr(OP_R, 1'b0, 0, 0, 1'b0);
    drain("back_to_back");
    @(negedge clk);
    checks++;
    if (cycle_count !== exp_cyc) begin
      errors++;
      $display("FAIL cycle_count: got %0d want %0d", cycle_count, exp_cyc);
    end
    checks++;
    if (instret_count !== exp_ret) begin
      errors++;
      $display("FAIL instret_count: got %0d want %0d", instret_count, exp_ret);
    end
    checks++;
    if (obs !== V_ZERO) begin
      errors++;
      $display("FAIL idle_after_stop: got %b want %b", obs, V_ZERO);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    run          = 1'b0;
    opcode       = 7'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch_jump();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
